// File: rtl/custom_axi_reg_top.sv
// Register-bus target for three RW registers plus a read-only ID word.
// One request in flight at a time; hardware d/de updates merge under bus writes.
module custom_axi_reg_top #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] ID_VALUE   = 32'hC0DE_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [31:0]           reg0_q_o,
  output logic [31:0]           reg1_q_o,
  output logic [31:0]           reg2_q_o,
  output logic                  reg0_qe_o,
  output logic                  reg1_qe_o,
  output logic                  reg2_qe_o,
  input  logic [31:0]           reg0_d_i,
  input  logic [31:0]           reg1_d_i,
  input  logic [31:0]           reg2_d_i,
  input  logic                  reg0_de_i,
  input  logic                  reg1_de_i,
  input  logic                  reg2_de_i
);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic        w_hi_zero;
  logic [1:0]  w_idx;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] w_q [3];
  logic [31:0] w_d [3];
  logic [2:0]  w_de;
  logic [2:0]  w_qe;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid_i) w_state_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign w_accept    = req_ready_o & req_valid_i;

  // With a 4-bit address there are no upper bits to range-check.
  if (ADDR_WIDTH > 4) begin : g_hi
    assign w_hi_zero = ~|req_addr_i[ADDR_WIDTH-1:4];
  end else begin : g_no_hi
    assign w_hi_zero = 1'b1;
  end

  assign w_idx = req_addr_i[3:2];
  assign w_err = (|req_addr_i[1:0]) | ~w_hi_zero | (req_write_i & (w_idx == 2'd3));

  always_comb begin
    w_rdata = '0;
    if (!w_err && !req_write_i) begin
      case (w_idx)
        2'd0:    w_rdata = w_q[0];
        2'd1:    w_rdata = w_q[1];
        2'd2:    w_rdata = w_q[2];
        default: w_rdata = ID_VALUE;
      endcase
    end
  end

  // Response is captured at the accept edge and frozen until the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= w_rdata;
      r_rsp_err   <= w_err;
    end else if (r_rsp_valid && rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

  assign w_d[0] = reg0_d_i;
  assign w_d[1] = reg1_d_i;
  assign w_d[2] = reg2_d_i;
  assign w_de   = {reg2_de_i, reg1_de_i, reg0_de_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_reg
    logic [31:0] r_q;
    logic        r_qe;
    logic        w_wr;
    logic [31:0] w_merged;

    assign w_wr = w_accept & req_write_i & ~w_err & (w_idx == 2'(gi));

    always_comb begin
      w_merged = r_q;
      for (int k = 0; k < 4; k++) begin
        if (req_wstrb_i[k]) w_merged[8*k +: 8] = req_wdata_i[8*k +: 8];
      end
    end

    // A bus write suppresses the hardware update for the whole word.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_q  <= '0;
        r_qe <= 1'b0;
      end else begin
        r_qe <= w_wr;
        if (w_wr)          r_q <= w_merged;
        else if (w_de[gi]) r_q <= w_d[gi];
      end
    end

    assign w_q[gi]  = r_q;
    assign w_qe[gi] = r_qe;
  end

  assign reg0_q_o  = w_q[0];
  assign reg1_q_o  = w_q[1];
  assign reg2_q_o  = w_q[2];
  assign reg0_qe_o = w_qe[0];
  assign reg1_qe_o = w_qe[1];
  assign reg2_qe_o = w_qe[2];

endmodule

// File: tb/tb_custom_axi_reg_top.sv
// Directed bench for custom_axi_reg_top; expected responses queue up at drive
// time and are popped when the response appears.
module tb_custom_axi_reg_top;

  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [31:0]   req_wdata_i;
  logic [3:0]    req_wstrb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic [31:0]   reg0_q_o, reg1_q_o, reg2_q_o;
  logic          reg0_qe_o, reg1_qe_o, reg2_qe_o;
  logic [31:0]   reg0_d_i, reg1_d_i, reg2_d_i;
  logic          reg0_de_i, reg1_de_i, reg2_de_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  custom_axi_reg_top #(.ADDR_WIDTH(AW), .ID_VALUE(32'hC0DE_0001)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .reg0_q_o(reg0_q_o), .reg1_q_o(reg1_q_o), .reg2_q_o(reg2_q_o),
    .reg0_qe_o(reg0_qe_o), .reg1_qe_o(reg1_qe_o), .reg2_qe_o(reg2_qe_o),
    .reg0_d_i(reg0_d_i), .reg1_d_i(reg1_d_i), .reg2_d_i(reg2_d_i),
    .reg0_de_i(reg0_de_i), .reg1_de_i(reg1_de_i), .reg2_de_i(reg2_de_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Presents a request and returns #1 after the accept edge.
  task automatic drive(input logic [AW-1:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    int n = 0;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    req_wstrb_i = strb;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 20) begin
      step();
      n++;
    end
    checks++;
    assert (req_ready_o === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout: observed ready %b expected 1", req_ready_o);
    end
    step();
    req_valid_i = 1'b0;
  endtask

  // Waits for a response and compares it with the oldest expectation.
  task automatic collect(input string tag);
    exp_t e;
    int n = 0;
    while (!rsp_valid_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata_o, e.rdata);
      chk({tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
    end
  endtask

  task automatic txn(input string tag, input logic [AW-1:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] exp_rdata, input logic exp_err);
    push(exp_rdata, exp_err);
    drive(addr, wr, wdata, strb);
    collect(tag);
    step();
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2);
    chk({tag, "_q0"}, reg0_q_o, e0);
    chk({tag, "_q1"}, reg1_q_o, e1);
    chk({tag, "_q2"}, reg2_q_o, e2);
    chk({tag, "_qe"}, {29'd0, reg2_qe_o, reg1_qe_o, reg0_qe_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
    req_wdata_i = '0; req_wstrb_i = '0; rsp_ready_i = 1'b1;
    reg0_d_i = '0; reg1_d_i = '0; reg2_d_i = '0;
    reg0_de_i = 1'b0; reg1_de_i = 1'b0; reg2_de_i = 1'b0;

    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk_regs("rst", 32'd0, 32'd0, 32'd0);
    rst_i = 1'b0;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    $display("reset released");

    txn("rd_id", 12'hC, 1'b0, '0, '0, 32'hC0DE_0001, 1'b0);
    $display("read 0xC done");
    txn("rd_r0", 12'h0, 1'b0, '0, '0, 32'd0, 1'b0);
    txn("rd_r1", 12'h4, 1'b0, '0, '0, 32'd0, 1'b0);
    txn("rd_r2", 12'h8, 1'b0, '0, '0, 32'd0, 1'b0);
    $display("reads of 0x0/0x4/0x8 done");

    push(32'd0, 1'b0);
    drive(12'h4, 1'b1, 32'hA5A5_1234, 4'b0101);
    chk("wr1_q", reg1_q_o, 32'h00A5_0034);
    chk("wr1_qe", 32'(reg1_qe_o), 32'd1);
    collect("wr1");
    step();
    chk("wr1_qe_drop", 32'(reg1_qe_o), 32'd0);
    txn("rd_r1_merged", 12'h4, 1'b0, '0, '0, 32'h00A5_0034, 1'b0);
    $display("partial write to 0x4 done");

    reg0_de_i = 1'b1;
    reg0_d_i  = 32'h2222_2222;
    push(32'd0, 1'b0);
    drive(12'h0, 1'b1, 32'h1111_1111, 4'hF);
    reg0_de_i = 1'b0;
    chk("wr0_vs_de_q", reg0_q_o, 32'h1111_1111);
    chk("wr0_vs_de_qe", 32'(reg0_qe_o), 32'd1);
    collect("wr0_vs_de");
    step();
    reg0_de_i = 1'b1;
    reg0_d_i  = 32'h3333_3333;
    step();
    reg0_de_i = 1'b0;
    chk("de0_q", reg0_q_o, 32'h3333_3333);
    chk("de0_qe", 32'(reg0_qe_o), 32'd0);
    step();
    chk("de0_qe_later", 32'(reg0_qe_o), 32'd0);
    txn("rd_r0_hw", 12'h0, 1'b0, '0, '0, 32'h3333_3333, 1'b0);
    $display("bus write vs hw update done");

    push(32'd0, 1'b1);
    drive(12'hC, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk_regs("err_wr_id", 32'h3333_3333, 32'h00A5_0034, 32'd0);
    collect("err_wr_id");
    step();
    push(32'd0, 1'b1);
    drive(12'h10, 1'b0, '0, '0);
    chk_regs("err_rd_hi", 32'h3333_3333, 32'h00A5_0034, 32'd0);
    collect("err_rd_hi");
    step();
    push(32'd0, 1'b1);
    drive(12'h6, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk_regs("err_wr_unal", 32'h3333_3333, 32'h00A5_0034, 32'd0);
    collect("err_wr_unal");
    step();
    $display("error cases done");

    rsp_ready_i = 1'b0;
    push(32'h00A5_0034, 1'b0);
    drive(12'h4, 1'b0, '0, '0);
    req_addr_i  = 12'h8;
    req_write_i = 1'b0;
    req_valid_i = 1'b1;
    push(32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(req_ready_o), 32'd0);
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rdata", rsp_rdata_o, 32'h00A5_0034);
      step();
    end
    collect("bp_first");
    rsp_ready_i = 1'b1;
    step();
    chk("bp_idle_ready", 32'(req_ready_o), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid_o), 32'd0);
    step();
    req_valid_i = 1'b0;
    collect("bp_second");
    step();
    $display("back-pressure done");

    rsp_ready_i = 1'b0;
    drive(12'h8, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("rr_q2_written", reg2_q_o, 32'hFFFF_FFFF);
    step();
    rst_i = 1'b1;
    step();
    chk("rr_valid", 32'(rsp_valid_o), 32'd0);
    chk("rr_q2", reg2_q_o, 32'd0);
    chk("rr_q0", reg0_q_o, 32'd0);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    chk("rr_ready", 32'(req_ready_o), 32'd1);
    step();
    chk("rr_valid_after", 32'(rsp_valid_o), 32'd0);
    $display("reset during response done");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
